// File: rtl/proc_io_bank.sv
// rtl/proc_io_bank.sv - buffered processor I/O port bank with one FIFO per channel
// Input FIFOs feed processor reads; output FIFOs drain processor writes to the outside world.

module proc_io_fifo #(
  parameter int NBW    = 28,
  parameter int FDEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [NBW-1:0] wdata,
  output logic [NBW-1:0] rdata,
  output logic           full,
  output logic           empty
);
  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [NBW-1:0] mem_q [FDEPTH];

  assign full  = (count_q == CW'(FDEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // Callers qualify push/pop against full/empty; pointers wrap naturally (power-of-2 depth).
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

module proc_io_bank #(
  parameter int NUIOIN = 4,
  parameter int NUIOOU = 4,
  parameter int NBW    = 28,
  parameter int FDEPTH = 4,
  localparam int AIW   = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AOW   = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUIOIN*NBW-1:0] s_data,
  input  logic [NUIOIN-1:0]     s_valid,
  output logic [NUIOIN-1:0]     s_ready,
  output logic [NUIOOU*NBW-1:0] m_data,
  output logic [NUIOOU-1:0]     m_valid,
  input  logic [NUIOOU-1:0]     m_ready,
  input  logic                  proc_req_in,
  input  logic [AIW-1:0]        addr_in,
  output logic [NBW-1:0]        proc_in_data,
  input  logic                  proc_out_en,
  input  logic [AOW-1:0]        addr_out,
  input  logic [NBW-1:0]        proc_out_data,
  output logic                  stall
);
  logic [NUIOIN-1:0] full_in, empty_in, push_in, pop_in;
  logic [NUIOOU-1:0] full_out, empty_out, push_out, pop_out;
  logic [NBW-1:0]    head_in  [NUIOIN];
  logic [NBW-1:0]    head_out [NUIOOU];
  logic              stall_in, stall_out;

  assign s_ready = ~full_in & {NUIOIN{~rst}};
  assign m_valid = ~empty_out;

  for (genvar i = 0; i < NUIOIN; i++) begin : g_in
    assign push_in[i] = s_valid[i] && s_ready[i];
    assign pop_in[i]  = proc_req_in && (addr_in == AIW'(i)) && !empty_in[i];
    proc_io_fifo #(.NBW(NBW), .FDEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push_in[i]), .pop(pop_in[i]),
      .wdata(s_data[i*NBW +: NBW]), .rdata(head_in[i]),
      .full(full_in[i]), .empty(empty_in[i])
    );
  end

  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    assign push_out[j] = proc_out_en && (addr_out == AOW'(j)) && !full_out[j];
    assign pop_out[j]  = m_valid[j] && m_ready[j];
    assign m_data[j*NBW +: NBW] = head_out[j];
    proc_io_fifo #(.NBW(NBW), .FDEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst), .push(push_out[j]), .pop(pop_out[j]),
      .wdata(proc_out_data), .rdata(head_out[j]),
      .full(full_out[j]), .empty(empty_out[j])
    );
  end

  // Addresses beyond the channel count match no channel: data reads 0 and nothing stalls.
  always_comb begin
    proc_in_data = '0;
    stall_in     = 1'b0;
    stall_out    = 1'b0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (addr_in == AIW'(i)) begin
        if (!empty_in[i]) proc_in_data = head_in[i];
        stall_in = proc_req_in && empty_in[i];
      end
    end
    for (int j = 0; j < NUIOOU; j++) begin
      if (addr_out == AOW'(j)) stall_out = proc_out_en && full_out[j];
    end
  end

  assign stall = (stall_in || stall_out) && !rst;
endmodule

// File: tb/tb_proc_io_bank.sv
// tb/tb_proc_io_bank.sv - self-checking bench for proc_io_bank
module tb_proc_io_bank;
  localparam int NI = 3, NO = 4, W = 28, D = 4;

  logic              clk = 1'b0, rst = 1'b1;
  logic [NI*W-1:0]   s_data = '0;
  logic [NI-1:0]     s_valid = '0, s_ready;
  logic [NO*W-1:0]   m_data;
  logic [NO-1:0]     m_valid, m_ready = '0;
  logic              proc_req_in = 1'b0, proc_out_en = 1'b0, stall;
  logic [1:0]        addr_in = '0, addr_out = '0;
  logic [W-1:0]      proc_in_data, proc_out_data = '0;
  int                checks = 0, errors = 0;

  typedef struct {
    logic         push;
    logic [W-1:0] wd;
    logic         pop;
    logic         rdy;
    logic         stl;
    logic [W-1:0] rd;
  } vec_t;
  vec_t tbl [14];

  logic [W-1:0] inq  [NI][$];
  logic [W-1:0] outq [NO][$];
  bit           pin  [NI];
  bit           mpop [NO];
  bit           pout, es;
  logic [W-1:0] epd;

  always #5 clk = ~clk;

  proc_io_bank #(.NUIOIN(NI), .NUIOOU(NO), .NBW(W), .FDEPTH(D)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .proc_req_in(proc_req_in), .addr_in(addr_in), .proc_in_data(proc_in_data),
    .proc_out_en(proc_out_en), .addr_out(addr_out), .proc_out_data(proc_out_data),
    .stall(stall)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    s_valid = '0; m_ready = '0; proc_req_in = 1'b0; proc_out_en = 1'b0;
  endtask

  task automatic put_s(input int i, input logic [W-1:0] v);
    s_data[i*W +: W] = v;
    s_valid[i] = 1'b1;
  endtask

  task automatic wr_out(input logic [1:0] ch, input logic [W-1:0] v);
    proc_out_en = 1'b1; addr_out = ch; proc_out_data = v;
  endtask

  function automatic logic [W-1:0] md(input int j);
    return m_data[j*W +: W];
  endfunction

  initial begin
    // ordering and wrap on input ch2: {push, word, pop, s_ready[2], stall, proc_in_data}
    tbl[0]  = '{1'b1, 28'h1, 1'b0, 1'b1, 1'b0, 28'h0};
    tbl[1]  = '{1'b1, 28'h2, 1'b0, 1'b1, 1'b0, 28'h1};
    tbl[2]  = '{1'b1, 28'h3, 1'b0, 1'b1, 1'b0, 28'h1};
    tbl[3]  = '{1'b1, 28'h4, 1'b0, 1'b1, 1'b0, 28'h1};
    tbl[4]  = '{1'b0, 28'h0, 1'b0, 1'b0, 1'b0, 28'h1};
    tbl[5]  = '{1'b0, 28'h0, 1'b1, 1'b0, 1'b0, 28'h1};
    tbl[6]  = '{1'b0, 28'h0, 1'b1, 1'b1, 1'b0, 28'h2};
    tbl[7]  = '{1'b1, 28'h5, 1'b0, 1'b1, 1'b0, 28'h3};
    tbl[8]  = '{1'b1, 28'h6, 1'b0, 1'b1, 1'b0, 28'h3};
    tbl[9]  = '{1'b0, 28'h0, 1'b1, 1'b0, 1'b0, 28'h3};
    tbl[10] = '{1'b0, 28'h0, 1'b1, 1'b1, 1'b0, 28'h4};
    tbl[11] = '{1'b0, 28'h0, 1'b1, 1'b1, 1'b0, 28'h5};
    tbl[12] = '{1'b0, 28'h0, 1'b1, 1'b1, 1'b0, 28'h6};
    tbl[13] = '{1'b0, 28'h0, 1'b1, 1'b1, 1'b1, 28'h0};

    // reset state with an active read strobe
    @(negedge clk); proc_req_in = 1'b1; addr_in = 2'd0;
    #1;
    chk("reset_s_ready", s_ready, 3'b000);
    chk("reset_m_valid", m_valid, 4'b0000);
    chk("reset_stall", stall, 1'b0);
    chk("reset_data", proc_in_data, 28'h0);
    @(negedge clk); rst = 1'b0; idle();
    #1 chk("post_reset_s_ready", s_ready, 3'b111);

    for (int k = 0; k < 14; k++) begin
      @(negedge clk); idle();
      addr_in = 2'd2; proc_req_in = tbl[k].pop;
      if (tbl[k].push) put_s(2, tbl[k].wd);
      #1;
      chk($sformatf("order%0d_s_ready2", k), s_ready[2], tbl[k].rdy);
      chk($sformatf("order%0d_stall", k), stall, tbl[k].stl);
      chk($sformatf("order%0d_data", k), proc_in_data, tbl[k].rd);
    end

    // asynchronous reset in the middle of traffic
    @(negedge clk); idle(); put_s(1, 28'h111); wr_out(2'd2, 28'h222);
    @(negedge clk); idle(); put_s(1, 28'h112);
    @(negedge clk); idle(); put_s(1, 28'h113);
    @(negedge clk); idle(); proc_req_in = 1'b1; addr_in = 2'd1;
    #1;
    chk("midrst_pre_data", proc_in_data, 28'h111);
    chk("midrst_pre_m_valid2", m_valid[2], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_s_ready", s_ready, 3'b000);
    chk("midrst_m_valid", m_valid, 4'b0000);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_data", proc_in_data, 28'h0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("midrst_after_s_ready", s_ready, 3'b111);
    chk("midrst_after_stall", stall, 1'b1);
    chk("midrst_after_data", proc_in_data, 28'h0);
    chk("midrst_after_m_valid", m_valid, 4'b0000);

    // processor write stall on a full output channel
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); idle(); wr_out(2'd3, 28'hA + 28'(k));
      #1 chk($sformatf("ostall%0d_stall", k), stall, k == 4);
    end
    @(negedge clk); idle(); wr_out(2'd3, 28'hE); m_ready[3] = 1'b1;
    #1;
    chk("ostall_release_m_valid3", m_valid[3], 1'b1);
    chk("ostall_release_m_data3", md(3), 28'hA);
    chk("ostall_release_stall", stall, 1'b1);
    @(negedge clk); idle(); wr_out(2'd3, 28'hE); m_ready[3] = 1'b1;
    #1;
    chk("ostall_accept_stall", stall, 1'b0);
    chk("ostall_accept_m_data3", md(3), 28'hB);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); idle(); m_ready[3] = 1'b1;
      #1;
      chk($sformatf("ostall_drain%0d_m_valid3", k), m_valid[3], 1'b1);
      chk($sformatf("ostall_drain%0d_m_data3", k), md(3), 28'hC + 28'(k));
    end
    @(negedge clk); idle();
    #1 chk("ostall_empty_m_valid3", m_valid[3], 1'b0);

    // full output ch0: external pop and processor push in the same cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); wr_out(2'd0, 28'h100 + 28'(k));
    end
    @(negedge clk); idle(); wr_out(2'd0, 28'h1FF); m_ready[0] = 1'b1;
    #1;
    chk("simul_full_stall", stall, 1'b1);
    chk("simul_full_m_data0", md(0), 28'h100);
    @(negedge clk); idle(); wr_out(2'd0, 28'h1FF);
    #1 chk("simul_count3_stall", stall, 1'b0);
    @(negedge clk); idle(); wr_out(2'd0, 28'h1FF);
    #1 chk("simul_refull_stall", stall, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); m_ready[0] = 1'b1;
      #1 chk($sformatf("simul_drain%0d_m_data0", k), md(0), (k == 3) ? 28'h1FF : 28'h101 + 28'(k));
    end
    @(negedge clk); idle();
    #1 chk("simul_drained_m_valid0", m_valid[0], 1'b0);

    // empty input ch0: external push and processor read in the same cycle
    @(negedge clk); idle(); put_s(0, 28'h5A5); proc_req_in = 1'b1; addr_in = 2'd0;
    #1;
    chk("simul_empty_stall", stall, 1'b1);
    chk("simul_empty_data", proc_in_data, 28'h0);
    @(negedge clk); idle(); proc_req_in = 1'b1; addr_in = 2'd0;
    #1;
    chk("simul_next_stall", stall, 1'b0);
    chk("simul_next_data", proc_in_data, 28'h5A5);
    @(negedge clk); idle(); proc_req_in = 1'b1; addr_in = 2'd0;
    #1 chk("simul_popped_stall", stall, 1'b1);

    // parallel pushes on all input channels, then an out-of-range read
    @(negedge clk); idle(); put_s(0, 28'hC0); put_s(1, 28'hC1); put_s(2, 28'hC2);
    @(negedge clk); idle(); proc_req_in = 1'b1; addr_in = 2'd3;
    #1;
    chk("oor_stall", stall, 1'b0);
    chk("oor_data", proc_in_data, 28'h0);
    for (int i = 0; i < NI; i++) begin
      @(negedge clk); idle(); proc_req_in = 1'b1; addr_in = 2'(i);
      #1;
      chk($sformatf("par%0d_stall", i), stall, 1'b0);
      chk($sformatf("par%0d_data", i), proc_in_data, 28'hC0 + 28'(i));
    end
    for (int i = 0; i < NI; i++) begin
      @(negedge clk); idle(); proc_req_in = 1'b1; addr_in = 2'(i);
      #1 chk($sformatf("par%0d_empty_stall", i), stall, 1'b1);
    end

    // randomized traffic against a queue model
    @(negedge clk); idle(); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < NI; i++) inq[i].delete();
    for (int j = 0; j < NO; j++) outq[j].delete();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) s_data[i*W +: W] = W'($urandom);
      s_valid = NI'($urandom);
      m_ready = NO'($urandom);
      if ((c / 250) % 2 == 1) begin
        s_valid = s_valid & NI'($urandom);
        m_ready = m_ready & NO'($urandom) & NO'($urandom);
      end
      proc_req_in = 1'($urandom);
      addr_in = 2'($urandom);
      proc_out_en = 1'($urandom);
      addr_out = 2'($urandom);
      proc_out_data = W'($urandom);
      #1;
      epd = '0;
      es = 1'b0;
      if (addr_in < NI) begin
        if (inq[addr_in].size() > 0) epd = inq[addr_in][0];
        else if (proc_req_in) es = 1'b1;
      end
      if (proc_out_en && outq[addr_out].size() == D) es = 1'b1;
      chk("rnd_stall", stall, es);
      chk("rnd_proc_in_data", proc_in_data, epd);
      for (int i = 0; i < NI; i++) chk($sformatf("rnd_s_ready%0d", i), s_ready[i], inq[i].size() < D);
      for (int j = 0; j < NO; j++) begin
        chk($sformatf("rnd_m_valid%0d", j), m_valid[j], outq[j].size() > 0);
        if (outq[j].size() > 0) chk($sformatf("rnd_m_data%0d", j), md(j), outq[j][0]);
      end
      for (int i = 0; i < NI; i++) pin[i] = s_valid[i] && (inq[i].size() < D);
      for (int j = 0; j < NO; j++) mpop[j] = m_ready[j] && (outq[j].size() > 0);
      pout = proc_out_en && (outq[addr_out].size() < D);
      if (proc_req_in && addr_in < NI) begin
        if (inq[addr_in].size() > 0) void'(inq[addr_in].pop_front());
      end
      for (int i = 0; i < NI; i++) if (pin[i]) inq[i].push_back(s_data[i*W +: W]);
      for (int j = 0; j < NO; j++) if (mpop[j]) void'(outq[j].pop_front());
      if (pout) outq[addr_out].push_back(proc_out_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
